// File: rtl/opl3_pkg.sv
// Shared OPL3 types: the register-file write record driven by the write arbiter.
package opl3_pkg;

   localparam int CLK_FREQ = 14_318_180;

   typedef struct packed {
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } opl3_wr_entry_t;

   typedef struct packed {
      logic       valid;
      logic       bank_num;
      logic [7:0] address;
      logic [7:0] data;
   } opl3_reg_wr_t;

endpackage

// File: rtl/opl3_reg_wr_arbiter.sv
// Two-requester arbiter (host, sequencer) for the single OPL3 register-file write port.
// Each requester has its own FIFO; writes are paced and never issued on a sample strobe.
module opl3_reg_wr_arbiter #(
   parameter int FIFO_DEPTH     = 4,
   parameter int MIN_WR_SPACING = 32,
   parameter int HOST_PRIORITY  = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          sample_clk_en,
   input  logic                          flush,
   input  logic                          req0_valid,
   output logic                          req0_ready,
   input  logic                          req0_bank_num,
   input  logic [7:0]                    req0_address,
   input  logic [7:0]                    req0_data,
   input  logic                          req1_valid,
   output logic                          req1_ready,
   input  logic                          req1_bank_num,
   input  logic [7:0]                    req1_address,
   input  logic [7:0]                    req1_data,
   output logic [$clog2(FIFO_DEPTH):0]   req0_level,
   output logic [$clog2(FIFO_DEPTH):0]   req1_level,
   output opl3_pkg::opl3_reg_wr_t        opl3_reg_wr,
   output logic                          busy
);
   import opl3_pkg::*;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int SP_W  = (MIN_WR_SPACING > 1) ? $clog2(MIN_WR_SPACING) : 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [SP_W-1:0]  SP_LOAD  = SP_W'(MIN_WR_SPACING - 1);

   // Reset asserts asynchronously and releases two edges after reset_n rises.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   logic [1:0][LVL_W-1:0] level_q, level_d;
   logic [1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SP_W-1:0]       spacing_q, spacing_d;
   logic                  last_grant_q, last_grant_d;
   opl3_reg_wr_t          wr_q, wr_d;
   opl3_wr_entry_t        mem_q [2][FIFO_DEPTH];

   opl3_wr_entry_t [1:0]  req_entry;
   opl3_wr_entry_t [1:0]  head;
   logic [1:0]            req_valid, ready, push, pop, not_empty;
   logic                  issue, grant;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      req_valid = {req1_valid, req0_valid};
      req_entry[0] = '{bank_num: req0_bank_num, address: req0_address, data: req0_data};
      req_entry[1] = '{bank_num: req1_bank_num, address: req1_address, data: req1_data};
      ready     = '0;
      push      = '0;
      not_empty = '0;
      for (int p = 0; p < 2; p++) begin
         head[p]      = mem_q[p][rd_ptr_q[p]];
         not_empty[p] = (level_q[p] != '0);
         // Held off while the reset synchroniser is still releasing, so no accepted write is dropped.
         ready[p]     = (level_q[p] != LVL_FULL) && !flush && rst_n;
         push[p]      = req_valid[p] && ready[p];
      end

      issue = (spacing_q == '0) && !sample_clk_en && !flush && (|not_empty);
      if (&not_empty) grant = (HOST_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
      else            grant = not_empty[1];
      pop = '0;
      if (issue) pop[grant] = 1'b1;

      for (int p = 0; p < 2; p++) begin
         if (flush) begin
            level_d[p]  = '0;
            wr_ptr_d[p] = '0;
            rd_ptr_d[p] = '0;
         end else begin
            level_d[p]  = level_q[p] + LVL_W'(push[p]) - LVL_W'(pop[p]);
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
         end
      end

      wr_d         = wr_q;
      wr_d.valid   = 1'b0;
      last_grant_d = last_grant_q;
      spacing_d    = (spacing_q != '0) ? spacing_q - 1'b1 : spacing_q;
      if (issue) begin
         wr_d         = '{valid: 1'b1, bank_num: head[grant].bank_num,
                          address: head[grant].address, data: head[grant].data};
         last_grant_d = grant;
         spacing_d    = SP_LOAD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         spacing_q    <= '0;
         last_grant_q <= 1'b1;
         wr_q         <= '0;
      end else begin
         level_q      <= level_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         spacing_q    <= spacing_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
      end
   end

   // NOTE: FIFO storage is not reset; the levels and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (push[p]) mem_q[p][wr_ptr_q[p]] <= req_entry[p];
      end
   end

   assign req0_ready  = ready[0];
   assign req1_ready  = ready[1];
   assign req0_level  = level_q[0];
   assign req1_level  = level_q[1];
   assign opl3_reg_wr = wr_q;
   assign busy        = (|not_empty) || (spacing_q != '0) || wr_q.valid;

endmodule
